// File: rtl/controlador_interrupciones_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, code width and
// the fixed-priority code helper.
package controlador_interrupciones_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_INJECT  = 2'b01,
    ST_SERVICE = 2'b10
  } estado_t;

  localparam int INT_CODE_W = 3;
  localparam int MAX_IRQ    = 7;
  localparam logic [MAX_IRQ-1:0] MASK_RESET = 7'h7F;

  // Lowest set index wins; the returned code is index + 1, zero when nothing is set.
  function automatic logic [INT_CODE_W-1:0] codigo_prioridad(input logic [MAX_IRQ-1:0] v);
    logic [INT_CODE_W-1:0] c;
    c = 3'd0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        c = INT_CODE_W'(i + 1);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/controlador_interrupciones_detector_flanco.sv
// Per-line synchroniser (SYNC_STAGES flops) followed by a rising-edge detector.
module detector_flanco #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic entrada,
  output logic flanco
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   previo_r;

  // Synchroniser shift chain plus one-cycle history of its output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r   <= {SYNC_STAGES{1'b0}};
      previo_r <= 1'b0;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], entrada};
      previo_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign flanco = sync_r[SYNC_STAGES-1] & ~previo_r;

endmodule

// File: rtl/controlador_interrupciones.sv
// Interrupt controller feeding the datapath's interrupciones input.
// Optional nested preemption is enabled by defining IRQ_NESTING_EN.
module controlador_interrupciones
  import controlador_interrupciones_pkg::*;
#(
  parameter int NUM_IRQ     = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_IRQ-1:0]    irq,
  input  logic                  ien,
  input  logic                  mask_we,
  input  logic [NUM_IRQ-1:0]    mask_in,
  input  logic                  eoi,
  output logic [INT_CODE_W-1:0] interrupciones,
  output logic                  busy,
  output logic [NUM_IRQ-1:0]    pendiente,
  output logic [NUM_IRQ-1:0]    en_servicio,
  output logic [NUM_IRQ-1:0]    mascara
);

  localparam logic [NUM_IRQ-1:0] UNO  = NUM_IRQ'(1);
  localparam logic [NUM_IRQ-1:0] CERO = {NUM_IRQ{1'b0}};

  estado_t               estado_r, estado_s;
  logic [INT_CODE_W-1:0] codigo_r, codigo_s, codigo_ganador_s;
  logic [NUM_IRQ-1:0]    pend_r, pend_s, serv_r, serv_s, masc_r, masc_s;
  logic [NUM_IRQ-1:0]    flanco_s, elig_s, ganador_s, limpiar_s;
  logic [MAX_IRQ-1:0]    elig_ext_s;
  logic                  busy_r;
`ifdef IRQ_NESTING_EN
  logic [NUM_IRQ-1:0]    serv_alta_s;
  logic                  preempt_s;
`endif

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_det
    detector_flanco #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_det (
      .clk    (clk),
      .reset  (reset),
      .entrada(irq[g]),
      .flanco (flanco_s[g])
    );
  end

  // Eligibility and fixed-priority winner selection.
  always_comb begin
    if (ien) begin
      elig_s = pend_r & ~masc_r;
    end else begin
      elig_s = CERO;
    end
    ganador_s  = elig_s & (~elig_s + UNO);
    elig_ext_s = {MAX_IRQ{1'b0}};
    elig_ext_s[NUM_IRQ-1:0] = elig_s;
    codigo_ganador_s = codigo_prioridad(elig_ext_s);
  end

`ifdef IRQ_NESTING_EN
  // Preempt only for lines strictly above the highest-priority in-service bit.
  always_comb begin
    serv_alta_s = serv_r & (~serv_r + UNO);
    preempt_s   = |(elig_s & (serv_alta_s - UNO));
  end
`endif

  // Next-state, code, in-service, mask and pending computation.
  always_comb begin
    estado_s  = estado_r;
    codigo_s  = codigo_r;
    serv_s    = serv_r;
    limpiar_s = CERO;
    if (mask_we) begin
      masc_s = mask_in;
    end else begin
      masc_s = masc_r;
    end
    case (estado_r)
      ST_IDLE: begin
        if (|elig_s) begin
          estado_s  = ST_INJECT;
          codigo_s  = codigo_ganador_s;
          serv_s    = serv_r | ganador_s;
          limpiar_s = ganador_s;
        end else begin
          codigo_s  = 3'd0;
        end
      end
      ST_INJECT: begin
        estado_s = ST_SERVICE;
        codigo_s = 3'd0;
      end
      ST_SERVICE: begin
        codigo_s = 3'd0;
`ifdef IRQ_NESTING_EN
        if (eoi) begin
          serv_s = serv_r & (serv_r - UNO);
          if (serv_s == CERO) begin
            estado_s = ST_IDLE;
          end else begin
            estado_s = ST_SERVICE;
          end
        end else if (preempt_s) begin
          estado_s  = ST_INJECT;
          codigo_s  = codigo_ganador_s;
          serv_s    = serv_r | ganador_s;
          limpiar_s = ganador_s;
        end else begin
          estado_s = ST_SERVICE;
        end
`else
        if (eoi) begin
          serv_s   = CERO;
          estado_s = ST_IDLE;
        end else begin
          estado_s = ST_SERVICE;
        end
`endif
      end
      default: begin
        estado_s = ST_IDLE;
        codigo_s = 3'd0;
        serv_s   = CERO;
      end
    endcase
    // A fresh edge wins over a same-cycle injection clear.
    pend_s = (pend_r & ~limpiar_s) | flanco_s;
  end

  // State and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_r <= ST_IDLE;
      codigo_r <= 3'd0;
      pend_r   <= CERO;
      serv_r   <= CERO;
      masc_r   <= MASK_RESET[NUM_IRQ-1:0];
      busy_r   <= 1'b0;
    end else begin
      estado_r <= estado_s;
      codigo_r <= codigo_s;
      pend_r   <= pend_s;
      serv_r   <= serv_s;
      masc_r   <= masc_s;
      busy_r   <= (estado_s != ST_IDLE);
    end
  end

  assign interrupciones = codigo_r;
  assign busy           = busy_r;
  assign pendiente      = pend_r;
  assign en_servicio    = serv_r;
  assign mascara        = masc_r;

endmodule

// File: tb/tb_controlador_interrupciones.sv
// Directed self-checking bench for controlador_interrupciones (IRQ_NESTING_EN aware).
module tb_controlador_interrupciones;

  logic       clk;
  logic       reset;
  logic [6:0] irq;
  logic       ien;
  logic       mask_we;
  logic [6:0] mask_in;
  logic       eoi;
  logic [2:0] interrupciones;
  logic       busy;
  logic [6:0] pendiente;
  logic [6:0] en_servicio;
  logic [6:0] mascara;

  int checks = 0;
  int errors = 0;

  controlador_interrupciones #(
    .NUM_IRQ(7),
    .SYNC_STAGES(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .irq           (irq),
    .ien           (ien),
    .mask_we       (mask_we),
    .mask_in       (mask_in),
    .eoi           (eoi),
    .interrupciones(interrupciones),
    .busy          (busy),
    .pendiente     (pendiente),
    .en_servicio   (en_servicio),
    .mascara       (mascara)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulso_eoi();
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
  endtask

  initial begin
    reset = 1'b0; irq = 7'h00; ien = 1'b0; mask_we = 1'b0; mask_in = 7'h00; eoi = 1'b0;
    tick(2);
    reset = 1'b1;

    // 1: build some state, then asynchronous reset mid-cycle
    mask_we = 1'b1; mask_in = 7'h00; ien = 1'b1; irq = 7'h7F;
    tick(1);
    mask_we = 1'b0;
    tick(3);
    chk("t1_pre_int", {29'd0, interrupciones}, 32'h1);
    tick(1);
    chk("t1_pre_pend", {25'd0, pendiente}, 32'h7E);
    #2 reset = 1'b0;
    #1;
    chk("t1_rst_int", {29'd0, interrupciones}, 32'h0);
    chk("t1_rst_busy", {31'd0, busy}, 32'h0);
    chk("t1_rst_pend", {25'd0, pendiente}, 32'h0);
    chk("t1_rst_serv", {25'd0, en_servicio}, 32'h0);
    chk("t1_rst_mask", {25'd0, mascara}, 32'h7F);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("t1_hold_int", {29'd0, interrupciones}, 32'h0);
    end
    irq = 7'h00;
    tick(1);
    reset = 1'b1;
    tick(2);

    // 2: single line 0 request, latency and eoi
    mask_we = 1'b1; mask_in = 7'h7E; ien = 1'b1;
    tick(1);
    mask_we = 1'b0; irq = 7'h01;
    tick(1);
    chk("t2_e0_int", {29'd0, interrupciones}, 32'h0);
    tick(1);
    chk("t2_e1_int", {29'd0, interrupciones}, 32'h0);
    tick(1);
    chk("t2_e2_int", {29'd0, interrupciones}, 32'h0);
    chk("t2_e2_pend", {25'd0, pendiente}, 32'h01);
    tick(1);
    chk("t2_e3_int", {29'd0, interrupciones}, 32'h1);
    chk("t2_e3_busy", {31'd0, busy}, 32'h1);
    chk("t2_e3_serv", {25'd0, en_servicio}, 32'h01);
    tick(1);
    chk("t2_e4_int", {29'd0, interrupciones}, 32'h0);
    chk("t2_e4_busy", {31'd0, busy}, 32'h1);
    irq = 7'h00;
    pulso_eoi();
    chk("t2_eoi_busy", {31'd0, busy}, 32'h0);
    chk("t2_eoi_serv", {25'd0, en_servicio}, 32'h0);
    tick(2);

    // 3: lines 2 and 5 together, fixed priority
    mask_we = 1'b1; mask_in = 7'h00;
    tick(1);
    mask_we = 1'b0; irq = 7'h24;
    tick(4);
    chk("t3_first_int", {29'd0, interrupciones}, 32'h3);
    chk("t3_first_serv", {25'd0, en_servicio}, 32'h04);
    tick(1);
    chk("t3_svc_pend", {25'd0, pendiente}, 32'h20);
    chk("t3_svc_int", {29'd0, interrupciones}, 32'h0);
    pulso_eoi();
    chk("t3_eoi_busy", {31'd0, busy}, 32'h0);
    tick(1);
    chk("t3_second_int", {29'd0, interrupciones}, 32'h6);
    chk("t3_second_serv", {25'd0, en_servicio}, 32'h20);
    tick(1);
    chk("t3_second_off", {29'd0, interrupciones}, 32'h0);
    pulso_eoi();
    chk("t3_end_pend", {25'd0, pendiente}, 32'h0);
    chk("t3_end_serv", {25'd0, en_servicio}, 32'h0);
    irq = 7'h00;
    tick(2);

    // 4: masked line latches pending, unmask releases it
    mask_we = 1'b1; mask_in = 7'h10;
    tick(1);
    mask_we = 1'b0; irq = 7'h10;
    tick(1);
    irq = 7'h00;
    tick(4);
    chk("t4_masked_pend", {25'd0, pendiente}, 32'h10);
    chk("t4_masked_int", {29'd0, interrupciones}, 32'h0);
    chk("t4_masked_busy", {31'd0, busy}, 32'h0);
    mask_we = 1'b1; mask_in = 7'h00;
    tick(1);
    mask_we = 1'b0;
    chk("t4_m_mask", {25'd0, mascara}, 32'h00);
    chk("t4_m_int", {29'd0, interrupciones}, 32'h0);
    tick(1);
    chk("t4_m1_int", {29'd0, interrupciones}, 32'h5);
    tick(1);
    chk("t4_m2_int", {29'd0, interrupciones}, 32'h0);
    pulso_eoi();
    tick(1);

    // 5: ien gating and no retrigger on held level
    ien = 1'b0; irq = 7'h08;
    tick(5);
    chk("t5_gated_pend", {25'd0, pendiente}, 32'h08);
    chk("t5_gated_int", {29'd0, interrupciones}, 32'h0);
    chk("t5_gated_busy", {31'd0, busy}, 32'h0);
    ien = 1'b1;
    tick(1);
    chk("t5_inj_int", {29'd0, interrupciones}, 32'h4);
    chk("t5_inj_pend", {25'd0, pendiente}, 32'h00);
    tick(1);
    chk("t5_off_int", {29'd0, interrupciones}, 32'h0);
    tick(3);
    chk("t5_held_pend", {25'd0, pendiente}, 32'h00);
    pulso_eoi();
    tick(3);
    chk("t5_after_int", {29'd0, interrupciones}, 32'h0);
    chk("t5_after_busy", {31'd0, busy}, 32'h0);
    chk("t5_after_pend", {25'd0, pendiente}, 32'h00);
    irq = 7'h00;
    tick(2);

    // 6: higher-priority request during service of line 3
    irq = 7'h08;
    tick(4);
    chk("t6_l3_int", {29'd0, interrupciones}, 32'h4);
    tick(1);
    irq = 7'h0A;
    tick(3);
    chk("t6_l1_pend", {25'd0, pendiente}, 32'h02);
    tick(1);
`ifdef IRQ_NESTING_EN
    chk("t6n_inj_int", {29'd0, interrupciones}, 32'h2);
    chk("t6n_inj_serv", {25'd0, en_servicio}, 32'h0A);
    tick(1);
    chk("t6n_off_int", {29'd0, interrupciones}, 32'h0);
    pulso_eoi();
    chk("t6n_eoi1_serv", {25'd0, en_servicio}, 32'h08);
    chk("t6n_eoi1_busy", {31'd0, busy}, 32'h1);
    pulso_eoi();
    chk("t6n_eoi2_serv", {25'd0, en_servicio}, 32'h00);
    chk("t6n_eoi2_busy", {31'd0, busy}, 32'h0);
`else
    chk("t6_wait_int", {29'd0, interrupciones}, 32'h0);
    chk("t6_wait_serv", {25'd0, en_servicio}, 32'h08);
    chk("t6_wait_pend", {25'd0, pendiente}, 32'h02);
    pulso_eoi();
    chk("t6_eoi_serv", {25'd0, en_servicio}, 32'h00);
    chk("t6_eoi_busy", {31'd0, busy}, 32'h0);
    tick(1);
    chk("t6_l1_int", {29'd0, interrupciones}, 32'h2);
    chk("t6_l1_serv", {25'd0, en_servicio}, 32'h02);
    tick(1);
    chk("t6_l1_off", {29'd0, interrupciones}, 32'h0);
    pulso_eoi();
    chk("t6_end_busy", {31'd0, busy}, 32'h0);
`endif
    irq = 7'h00;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controlador_interrupciones.md
Name: controlador_interrupciones

Overview:
Interrupt controller that sits directly upstream of the single-cycle CPU datapath. It synchronises up to 7 device request lines, latches rising edges as pending and applies a mask and a global enable. Its registered 3-bit output feeds the datapath's `interrupciones` input, which substitutes the vector instruction.
- Fixed priority: line 0 is highest.
- The output code is (index + 1), so line 0 produces 3'b001 and fetches vector 16'hEFFF.
- Code 0 means no interrupt.

Parameters:
NUM_IRQ, 7, number of request lines (1..7; limited by the 3-bit code).
SYNC_STAGES, 2, flip-flop depth of each request-line synchroniser (minimum 2).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
irq  in  NUM_IRQ  device request lines; asynchronous, rising-edge sensitive.
ien  in  1  global interrupt enable from the control unit.
mask_we  in  1  mask register write strobe.
mask_in  in  NUM_IRQ  new mask value; 1 = line disabled.
eoi  in  1  end-of-interrupt pulse from the control unit (return from handler).
interrupciones  out  3  registered interrupt code to the datapath.
busy  out  1  high when the state is INJECT or SERVICE.
pendiente  out  NUM_IRQ  pending register (status).
en_servicio  out  NUM_IRQ  in-service register (status).
mascara  out  NUM_IRQ  mask register readback.

Behaviour:
- Reset (asynchronous, reset=0), effective immediately without a clock edge:
  - synchroniser and edge-history flops = 0;
  - pendiente = 0, en_servicio = 0, interrupciones = 0, busy = 0;
  - mascara = all ones; state = IDLE.
- Synchroniser: each irq bit passes through SYNC_STAGES flops. Edge = synchronised output high AND previous-cycle value low.
- Pending: a detected edge sets pendiente[i] on the next edge.
  - The bit clears when line i is injected.
  - If a set and a clear of the same bit occur in the same cycle, set wins.
  - A level held high does not retrigger.
- Mask: mascara loads mask_in on a clk edge with mask_we=1. Masked lines still latch pending but are not eligible.
- Eligibility: elig = pendiente & ~mascara, qualified by ien=1. The winner is the lowest set index of elig.
- FSM (2-bit state):
  - IDLE: if elig ≠ 0, go to INJECT on the next edge. On that edge: interrupciones ← winner + 1, en_servicio[winner] ← 1, pendiente[winner] ← 0.
  - INJECT: lasts exactly one cycle. Next edge: interrupciones ← 0, go to SERVICE.
  - SERVICE: eoi=1 clears the in-service bit and returns to IDLE on that edge. eoi in IDLE or INJECT is ignored.
- Latency (edge 0 = first clk edge that samples irq high): interrupciones is nonzero during exactly the one cycle following edge SYNC_STAGES+1, provided the line is unmasked, ien=1 and the state is IDLE.
- A request arriving while busy stays pending and is served after eoi. The earliest re-injection is on the edge after the return to IDLE.
- ien dropping while in SERVICE does not abort the handler. It only blocks new injections.
- interrupciones is driven straight from a flop; there is no combinational path from irq.

Optional Feature:
IRQ_NESTING_EN
- Defined:
  - In SERVICE, an eligible line with priority strictly higher than the highest-priority en_servicio bit injects again (SERVICE→INJECT).
  - en_servicio accumulates bits.
  - eoi clears the highest-priority set bit.
  - The FSM returns to IDLE only when en_servicio becomes 0; otherwise it stays in SERVICE.
  - Equal or lower priority waits.
- Undefined: single level; en_servicio is one-hot or zero; no preemption.

Decomposition:
- Shared package:
  - state encodings IDLE=2'b00, INJECT=2'b01, SERVICE=2'b10;
  - INT_CODE_W=3, MAX_IRQ=7, MASK_RESET=all ones.
- Sub-module detector_flanco: SYNC_STAGES synchroniser plus rising-edge detector, instantiated NUM_IRQ times through generate.
- The priority encoder and FSM stay in the top module.

Test Plan:
1. reset=0 mid-cycle with irq=7'h7F → all outputs 0, mascara=7'h7F, asynchronously, before the next clk edge; hold 3 cycles, no injection.
2. mask_in=7'h7E, ien=1, rising edge on irq[0] at edge 0 → interrupciones=3'b001 for only the cycle after edge 3; busy=1; en_servicio=7'h01; eoi pulse → busy=0, en_servicio=0.
3. mask=0, ien=1, irq[2] and irq[5] rise together → 3'b011 first, pendiente=7'h20 during service; after eoi, 3'b110; both bits end at 0.
4. mask bit 4 set, pulse irq[4] → pendiente=7'h10, interrupciones stays 0; write mask=0 at edge m → 3'b101 during the cycle after edge m+1.
5. ien=0 with pendiente=7'h08 → no injection; irq[3] held high, no retrigger; ien=1 → single 3'b100 pulse.
6. IRQ_NESTING_EN, line 3 in SERVICE, irq[1] rises → 3'b010 injected, en_servicio=7'h0A; eoi → 7'h08, still busy; second eoi → IDLE. Without the macro, irq[1] waits for eoi.
